// File: rtl/servo_pkg.sv
// servo_pkg: shared definitions for the servo slew controller.
//   - APB register offsets (PADDR[3:2] word index)
//   - controller state encoding
//   - default frame period / pulse-width limits
//   - clamp helper for pulse widths
package servo_pkg;

  localparam logic [1:0] ADDR_TARGET  = 2'd0;
  localparam logic [1:0] ADDR_STEP    = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_CURRENT = 2'd3;

  localparam int unsigned PERIOD_DEF   = 2000000;
  localparam int unsigned PW_MIN_DEF   = 100000;
  localparam int unsigned PW_MAX_DEF   = 200000;
  localparam int unsigned STEP_RST_DEF = 1000;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_UPDATE = 2'd2
  } servo_state_e;

  function automatic logic [31:0] clamp_pw(input logic [31:0] v,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: free-running frame counter, 0..PERIOD then wrap.
// Period matches the downstream PWM generator so updates land on frame edges.
// Ports:
//   PCLK, PRESETn : clock, synchronous active-low reset
//   frame_tick    : high for the single cycle where count == PERIOD
module servo_frame_timer #(
  parameter int unsigned PERIOD = 2000000
) (
  input  logic PCLK,
  input  logic PRESETn,
  output logic frame_tick
);

  localparam logic [31:0] TERM = PERIOD;

  logic [31:0] cnt_q;

  always_ff @(posedge PCLK) begin
    if (!PRESETn)          cnt_q <= '0;
    else if (cnt_q == TERM) cnt_q <= '0;
    else                   cnt_q <= cnt_q + 32'd1;
  end

  assign frame_tick = (cnt_q == TERM);

endmodule

// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: APB register block that rate-limits servo moves.
// Software writes TARGET; once per frame the commanded width (CURRENT) moves
// toward it by at most STEP, and each move is pushed to the PWM generator as a
// one-cycle servo_write strobe with pw_out.
// Ports:
//   PCLK, PRESETn         : clock, synchronous active-low reset
//   PSEL/PENABLE/PWRITE   : APB control; PADDR[3:2] selects the register
//   PWDATA/PRDATA/PREADY  : APB data; zero wait states (PREADY = 1)
//   servo_write, pw_out   : strobe + width to the PWM generator
//   busy                  : enable & (CURRENT != TARGET)
module servo_slew_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD   = PERIOD_DEF,
  parameter int unsigned PW_MIN   = PW_MIN_DEF,
  parameter int unsigned PW_MAX   = PW_MAX_DEF,
  parameter int unsigned STEP_RST = STEP_RST_DEF
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        servo_write,
  output logic [31:0] pw_out,
  output logic        busy
);

  localparam logic [31:0] PW_LO  = PW_MIN;
  localparam logic [31:0] PW_HI  = PW_MAX;
  localparam logic [31:0] PW_CTR = (PW_MIN + PW_MAX) / 2;
  localparam logic [31:0] STEP_R = STEP_RST;

  servo_state_e state_q, state_d;
  logic [31:0]  target_q, step_q, current_q, pw_out_q;
  logic [31:0]  cur_d, pw_d, cur_step;
  logic         enable_q, strobe_q, strobe_d;
  logic         frame_tick, wr_en;
  logic [32:0]  diff, mag;
  logic         unused;

  assign unused = ^PADDR[1:0];

  servo_frame_timer #(.PERIOD(PERIOD)) u_timer (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .frame_tick (frame_tick)
  );

  assign wr_en  = PSEL & PENABLE & PWRITE;
  assign PREADY = 1'b1;

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR[3:2])
        ADDR_TARGET:  PRDATA = target_q;
        ADDR_STEP:    PRDATA = step_q;
        ADDR_CTRL:    PRDATA = {31'd0, enable_q};
        ADDR_CURRENT: PRDATA = current_q;
        default:      PRDATA = '0;
      endcase
    end
  end

  // Signed 33-bit distance; a step that would reach or pass TARGET lands on
  // it exactly, so CURRENT can never overshoot or leave the clamped range.
  assign diff = {1'b0, target_q} - {1'b0, current_q};
  assign mag  = diff[32] ? (33'd0 - diff) : diff;

  always_comb begin
    if (step_q == '0 || mag <= {1'b0, step_q}) cur_step = target_q;
    else if (diff[32])                         cur_step = current_q - step_q;
    else                                       cur_step = current_q + step_q;
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = current_q;
    strobe_d = 1'b0;
    pw_d     = pw_out_q;
    case (state_q)
      S_INIT: begin
        // PWM generator width has no reset; seed it with the centre value.
        strobe_d = 1'b1;
        pw_d     = PW_CTR;
        state_d  = S_IDLE;
      end
      S_IDLE: begin
        if (frame_tick && enable_q && (current_q != target_q)) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        cur_d    = cur_step;
        strobe_d = 1'b1;
        pw_d     = cur_step;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= S_INIT;
      target_q  <= PW_CTR;
      current_q <= PW_CTR;
      step_q    <= STEP_R;
      enable_q  <= 1'b0;
      strobe_q  <= 1'b0;
      pw_out_q  <= PW_CTR;
    end else begin
      state_q   <= state_d;
      current_q <= cur_d;
      strobe_q  <= strobe_d;
      pw_out_q  <= pw_d;
      if (wr_en) begin
        case (PADDR[3:2])
          ADDR_TARGET: target_q <= clamp_pw(PWDATA, PW_LO, PW_HI);
          ADDR_STEP:   step_q   <= PWDATA;
          ADDR_CTRL:   enable_q <= PWDATA[0];
          default: ;
        endcase
      end
    end
  end

  assign servo_write = strobe_q;
  assign pw_out      = pw_out_q;
  assign busy        = enable_q & (current_q != target_q);

endmodule

// File: tb/tb_servo_slew_ctrl.sv
module tb_servo_slew_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, servo_write, busy;
  logic [31:0] pw_out;

  localparam logic [3:0] A_TGT = 4'h0, A_STP = 4'h4, A_CTL = 4'h8, A_CUR = 4'hC;

  servo_slew_ctrl #(.PERIOD(99), .PW_MIN(100), .PW_MAX(200), .STEP_RST(10)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .servo_write(servo_write), .pw_out(pw_out), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] pw;
    int          gap;   // expected cycles since previous strobe, 0 = don't care
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    forever begin
      @(posedge PCLK); #1;
      cyc++;
      if (servo_write === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe act=%0d exp=none", pw_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("strobe_pw", pw_out, e.pw);
          if (e.gap != 0) chk("strobe_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic push(input logic [31:0] pw, input int gap);
    exp_t e;
    e.pw = pw; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    #2;
    chk(name, PRDATA, exp);
    PSEL = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge PCLK);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout act=%0d exp=0 pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  initial begin
    // Reset state and centre strobe on release
    idle(3);
    #1;
    chk("rst_servo_write", {31'd0, servo_write}, 32'd0);
    chk("rst_pw_out", pw_out, 32'd150);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("pready", {31'd0, PREADY}, 32'd1);
    push(32'd150, 0);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("init_strobe", {31'd0, servo_write}, 32'd1);
    chk("init_pw", pw_out, 32'd150);
    drain();
    idle(250);                        // enable=0: no further strobes
    apb_rd_chk("rd_step_rst", A_STP, 32'd10);
    apb_rd_chk("rd_ctrl_rst", A_CTL, 32'd0);

    // Ramp up 150 -> 185
    push(32'd160, 0); push(32'd170, 100); push(32'd180, 100); push(32'd185, 100);
    apb_wr(A_TGT, 32'd185);
    apb_wr(A_CTL, 32'd1);
    #1 chk("busy_ramp", {31'd0, busy}, 32'd1);
    drain();
    idle(5);
    chk("busy_done", {31'd0, busy}, 32'd0);
    apb_rd_chk("rd_cur_185", A_CUR, 32'd185);
    apb_wr(A_CUR, 32'd111);           // read-only
    apb_rd_chk("rd_cur_ro", A_CUR, 32'd185);

    // Clamping and STEP=0
    apb_wr(A_CTL, 32'd0);
    apb_wr(A_TGT, 32'd5);
    apb_rd_chk("clamp_lo", A_TGT, 32'd100);
    apb_wr(A_TGT, 32'hFFFF_FFFF);
    apb_rd_chk("clamp_hi", A_TGT, 32'd200);
    #1 chk("busy_disabled", {31'd0, busy}, 32'd0);
    apb_wr(A_STP, 32'd0);
    apb_wr(A_TGT, 32'd120);
    push(32'd120, 0);
    apb_wr(A_CTL, 32'hFFFF_FFFF);
    apb_rd_chk("ctrl_bit0_only", A_CTL, 32'd1);
    drain();
    idle(250);
    apb_rd_chk("rd_cur_120", A_CUR, 32'd120);

    // Retarget mid-ramp
    apb_wr(A_CTL, 32'd0);
    apb_wr(A_STP, 32'd30);
    apb_wr(A_TGT, 32'd150);
    push(32'd150, 0);
    apb_wr(A_CTL, 32'd1);
    drain();
    apb_wr(A_STP, 32'd20);
    push(32'd170, 0);
    apb_wr(A_TGT, 32'd200);
    drain();
    push(32'd160, 100);
    apb_wr(A_TGT, 32'd160);
    drain();
    idle(250);
    apb_rd_chk("rd_cur_160", A_CUR, 32'd160);

    // Disable / resume
    apb_wr(A_STP, 32'd10);
    push(32'd170, 0);
    apb_wr(A_TGT, 32'd190);
    drain();
    apb_wr(A_CTL, 32'd0);
    idle(300);
    apb_rd_chk("rd_cur_hold", A_CUR, 32'd170);
    #1 chk("busy_hold", {31'd0, busy}, 32'd0);
    push(32'd180, 0); push(32'd190, 100);
    apb_wr(A_CTL, 32'd1);
    drain();
    apb_rd_chk("rd_cur_190", A_CUR, 32'd190);

    // Reset mid-ramp
    push(32'd180, 0);
    apb_wr(A_TGT, 32'd100);
    drain();
    @(negedge PCLK); PRESETn = 1'b0;
    push(32'd150, 0);
    idle(2);
    #1;
    chk("rst2_servo_write", {31'd0, servo_write}, 32'd0);
    chk("rst2_pw_out", pw_out, 32'd150);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("init2_strobe", {31'd0, servo_write}, 32'd1);
    drain();
    apb_rd_chk("rd_tgt_rst", A_TGT, 32'd150);
    apb_rd_chk("rd_cur_rst", A_CUR, 32'd150);
    apb_rd_chk("rd_stp_rst", A_STP, 32'd10);
    apb_rd_chk("rd_ctl_rst", A_CTL, 32'd0);
    idle(250);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
